// File: rtl/yuv_rgb_pair_converter_pkg.sv
// Shared types, coefficients and the saturating clip for the YUV->RGB stage.
package yuv_rgb_pkg;

  // Sequencer states: accept, five multiply steps, then hold the result.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4,
    S_M4   = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  // Q16 conversion coefficients.
  localparam logic signed [31:0] COEF_Y  = 32'sd76284;
  localparam logic signed [31:0] COEF_RV = 32'sd104595;
  localparam logic signed [31:0] COEF_GU = 32'sd25624;
  localparam logic signed [31:0] COEF_GV = 32'sd53281;
  localparam logic signed [31:0] COEF_BU = 32'sd132251;

  // Black level for luma and zero point for chroma.
  localparam logic [8:0] Y_OFFSET = 9'd16;
  localparam logic [8:0] C_OFFSET = 9'd128;

  // Saturate a signed Q16 accumulator to an 8-bit channel value.
  function automatic logic [7:0] clip8(input logic signed [31:0] acc);
    if (acc[31]) begin
      return 8'd0;
    end else if (acc[31:24] != 8'd0) begin
      return 8'd255;
    end else begin
      return acc[23:16];
    end
  endfunction

endpackage

// File: rtl/yuv_rgb_pair_converter_clip8.sv
// Combinational saturate of one 32-bit signed accumulator to 8 bits.
module rgb_clip8
  import yuv_rgb_pkg::*;
(
  input  logic signed [31:0] acc_i,
  output logic        [7:0]  pix_o
);

  assign pix_o = clip8(acc_i);

endmodule

// File: rtl/yuv_rgb_pair_converter.sv
// Converts one even/odd YUV pixel pair to clipped RGB using two shared
// multipliers stepped through five multiply states.
module yuv_rgb_pair_converter
  import yuv_rgb_pkg::*;
(
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Y_even,
  input  logic [7:0]  Y_odd,
  input  logic [7:0]  U_even,
  input  logic [7:0]  U_odd,
  input  logic [7:0]  V_even,
  input  logic [7:0]  V_odd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  R_even,
  output logic [7:0]  G_even,
  output logic [7:0]  B_even,
  output logic [7:0]  R_odd,
  output logic [7:0]  G_odd,
  output logic [7:0]  B_odd,
  output logic [15:0] RGB_word0,
  output logic [15:0] RGB_word1,
  output logic [15:0] RGB_word2
);

  state_t state_q;

  logic signed [8:0] yEven_q, yOdd_q, uEven_q, uOdd_q, vEven_q, vOdd_q;

  logic signed [31:0] accREven_q, accGEven_q, accBEven_q;
  logic signed [31:0] accROdd_q,  accGOdd_q,  accBOdd_q;
  logic signed [31:0] accREven_d, accGEven_d, accBEven_d;
  logic signed [31:0] accROdd_d,  accGOdd_d,  accBOdd_d;

  logic signed [31:0] coefSel;
  logic signed [8:0]  opEven, opOdd;
  logic signed [31:0] opEvenExt, opOddExt;
  logic signed [31:0] prodEven, prodOdd;

  logic [7:0] rEvenClip, gEvenClip, bEvenClip;
  logic [7:0] rOddClip,  gOddClip,  bOddClip;

  logic       outValid_q;
  logic [7:0] rEven_q, gEven_q, bEven_q, rOdd_q, gOdd_q, bOdd_q;

  // Ready only while idle and out of reset, so nothing is accepted during reset.
  assign in_ready = (state_q == S_IDLE) && resetn;

  // Pick the coefficient and the even/odd operands for this multiply step.
  always_comb begin
    coefSel = '0;
    opEven  = '0;
    opOdd   = '0;
    case (state_q)
      S_M0: begin coefSel = COEF_Y;  opEven = yEven_q; opOdd = yOdd_q; end
      S_M1: begin coefSel = COEF_RV; opEven = vEven_q; opOdd = vOdd_q; end
      S_M2: begin coefSel = COEF_GU; opEven = uEven_q; opOdd = uOdd_q; end
      S_M3: begin coefSel = COEF_GV; opEven = vEven_q; opOdd = vOdd_q; end
      S_M4: begin coefSel = COEF_BU; opEven = uEven_q; opOdd = uOdd_q; end
      default: begin end
    endcase
  end

  assign opEvenExt = 32'(opEven);
  assign opOddExt  = 32'(opOdd);
  assign prodEven  = coefSel * opEvenExt;
  assign prodOdd   = coefSel * opOddExt;

  // Next accumulator values; in S_M4 these are the finished sums fed to the clips.
  always_comb begin
    accREven_d = accREven_q;
    accGEven_d = accGEven_q;
    accBEven_d = accBEven_q;
    accROdd_d  = accROdd_q;
    accGOdd_d  = accGOdd_q;
    accBOdd_d  = accBOdd_q;
    case (state_q)
      S_M0: begin
        accREven_d = prodEven;
        accGEven_d = prodEven;
        accBEven_d = prodEven;
        accROdd_d  = prodOdd;
        accGOdd_d  = prodOdd;
        accBOdd_d  = prodOdd;
      end
      S_M1: begin
        accREven_d = accREven_q + prodEven;
        accROdd_d  = accROdd_q + prodOdd;
      end
      S_M2, S_M3: begin
        accGEven_d = accGEven_q - prodEven;
        accGOdd_d  = accGOdd_q - prodOdd;
      end
      S_M4: begin
        accBEven_d = accBEven_q + prodEven;
        accBOdd_d  = accBOdd_q + prodOdd;
      end
      default: begin end
    endcase
  end

  rgb_clip8 uClipREven (.acc_i(accREven_d), .pix_o(rEvenClip));
  rgb_clip8 uClipGEven (.acc_i(accGEven_d), .pix_o(gEvenClip));
  rgb_clip8 uClipBEven (.acc_i(accBEven_d), .pix_o(bEvenClip));
  rgb_clip8 uClipROdd  (.acc_i(accROdd_d),  .pix_o(rOddClip));
  rgb_clip8 uClipGOdd  (.acc_i(accGOdd_d),  .pix_o(gOddClip));
  rgb_clip8 uClipBOdd  (.acc_i(accBOdd_d),  .pix_o(bOddClip));

  // Sequencer: capture samples, step the multiplies, register and hold the result.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      yEven_q    <= '0;
      yOdd_q     <= '0;
      uEven_q    <= '0;
      uOdd_q     <= '0;
      vEven_q    <= '0;
      vOdd_q     <= '0;
      accREven_q <= '0;
      accGEven_q <= '0;
      accBEven_q <= '0;
      accROdd_q  <= '0;
      accGOdd_q  <= '0;
      accBOdd_q  <= '0;
      outValid_q <= 1'b0;
      rEven_q    <= '0;
      gEven_q    <= '0;
      bEven_q    <= '0;
      rOdd_q     <= '0;
      gOdd_q     <= '0;
      bOdd_q     <= '0;
    end else begin
      accREven_q <= accREven_d;
      accGEven_q <= accGEven_d;
      accBEven_q <= accBEven_d;
      accROdd_q  <= accROdd_d;
      accGOdd_q  <= accGOdd_d;
      accBOdd_q  <= accBOdd_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            yEven_q <= {1'b0, Y_even} - Y_OFFSET;
            yOdd_q  <= {1'b0, Y_odd}  - Y_OFFSET;
            uEven_q <= {1'b0, U_even} - C_OFFSET;
            uOdd_q  <= {1'b0, U_odd}  - C_OFFSET;
            vEven_q <= {1'b0, V_even} - C_OFFSET;
            vOdd_q  <= {1'b0, V_odd}  - C_OFFSET;
            state_q <= S_M0;
          end
        end
        S_M0: state_q <= S_M1;
        S_M1: state_q <= S_M2;
        S_M2: state_q <= S_M3;
        S_M3: state_q <= S_M4;
        S_M4: begin
          rEven_q    <= rEvenClip;
          gEven_q    <= gEvenClip;
          bEven_q    <= bEvenClip;
          rOdd_q     <= rOddClip;
          gOdd_q     <= gOddClip;
          bOdd_q     <= bOddClip;
          outValid_q <= 1'b1;
          state_q    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = outValid_q;
  assign R_even    = rEven_q;
  assign G_even    = gEven_q;
  assign B_even    = bEven_q;
  assign R_odd     = rOdd_q;
  assign G_odd     = gOdd_q;
  assign B_odd     = bOdd_q;
  assign RGB_word0 = {rEven_q, gEven_q};
  assign RGB_word1 = {bEven_q, rOdd_q};
  assign RGB_word2 = {gOdd_q, bOdd_q};

endmodule

// File: tb/tb_yuv_rgb_pair_converter.sv
// Directed self-checking bench for yuv_rgb_pair_converter.
module tb_yuv_rgb_pair_converter;

  logic        CLOCK_50_I;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Y_even, Y_odd, U_even, U_odd, V_even, V_odd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  R_even, G_even, B_even, R_odd, G_odd, B_odd;
  logic [15:0] RGB_word0, RGB_word1, RGB_word2;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  yuv_rgb_pair_converter dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y_even    (Y_even),
    .Y_odd     (Y_odd),
    .U_even    (U_even),
    .U_odd     (U_odd),
    .V_even    (V_even),
    .V_odd     (V_odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R_even    (R_even),
    .G_even    (G_even),
    .B_even    (B_even),
    .R_odd     (R_odd),
    .G_odd     (G_odd),
    .B_odd     (B_odd),
    .RGB_word0 (RGB_word0),
    .RGB_word1 (RGB_word1),
    .RGB_word2 (RGB_word2)
  );

  // 50 MHz clock.
  initial begin
    CLOCK_50_I = 1'b0;
    forever #10 CLOCK_50_I = ~CLOCK_50_I;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ye, input logic [7:0] yo,
                               input logic [7:0] ue, input logic [7:0] uo,
                               input logic [7:0] ve, input logic [7:0] vo);
    Y_even = ye; Y_odd = yo;
    U_even = ue; U_odd = uo;
    V_even = ve; V_odd = vo;
  endtask

  task automatic checkPixels(input string tag,
                             input logic [7:0] re, input logic [7:0] ge, input logic [7:0] be,
                             input logic [7:0] ro, input logic [7:0] go, input logic [7:0] bo);
    checkOutput({tag, " R_even"}, 32'(R_even), 32'(re));
    checkOutput({tag, " G_even"}, 32'(G_even), 32'(ge));
    checkOutput({tag, " B_even"}, 32'(B_even), 32'(be));
    checkOutput({tag, " R_odd"},  32'(R_odd),  32'(ro));
    checkOutput({tag, " G_odd"},  32'(G_odd),  32'(go));
    checkOutput({tag, " B_odd"},  32'(B_odd),  32'(bo));
    checkOutput({tag, " word0"},  32'(RGB_word0), 32'({re, ge}));
    checkOutput({tag, " word1"},  32'(RGB_word1), 32'({be, ro}));
    checkOutput({tag, " word2"},  32'(RGB_word2), 32'({go, bo}));
  endtask

  // Accept one pair, wait (bounded) for the result, check latency and in_ready.
  // With scramble set, the input pins are overwritten during every multiply cycle.
  task automatic convertPair(input string tag, input bit scramble);
    int lat;
    checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (scramble) applyStimulus(8'($urandom), 8'($urandom), 8'($urandom),
                                  8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd6);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic releaseOutput(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int sawValid;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    // Reset state.
    tick();
    tick();
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkPixels("reset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    resetn = 1'b1;
    tick();
    checkOutput("idle in_ready", 32'(in_ready), 32'd1);

    // Black: every offset zero.
    applyStimulus(8'd16, 8'd16, 8'd128, 8'd128, 8'd128, 8'd128);
    convertPair("black", 1'b0);
    checkPixels("black", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    releaseOutput("black");

    // White: even just below saturation, odd saturates high.
    applyStimulus(8'd235, 8'd255, 8'd128, 8'd128, 8'd128, 8'd128);
    convertPair("white", 1'b0);
    checkPixels("white", 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255);
    releaseOutput("white");

    // Red: G and B go negative and clip to zero.
    applyStimulus(8'd81, 8'd81, 8'd90, 8'd90, 8'd240, 8'd240);
    convertPair("red", 1'b0);
    checkPixels("red", 8'd254, 8'd0, 8'd0, 8'd254, 8'd0, 8'd0);

    // Stall the consumer for 20 cycles with a competing pair on the inputs.
    applyStimulus(8'd235, 8'd255, 8'd128, 8'd128, 8'd128, 8'd128);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("stall words", {RGB_word1, RGB_word0}, {16'h00FE, 16'hFE00});
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    end
    checkOutput("stall out_valid", 32'(out_valid), 32'd1);
    checkPixels("stall", 8'd254, 8'd0, 8'd0, 8'd254, 8'd0, 8'd0);
    in_valid = 1'b0;
    releaseOutput("stall");
    checkPixels("retained", 8'd254, 8'd0, 8'd0, 8'd254, 8'd0, 8'd0);

    // Reset in S_M2 discards the pair in flight.
    applyStimulus(8'd235, 8'd255, 8'd128, 8'd128, 8'd128, 8'd128);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd0);
    checkPixels("midreset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    resetn = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) sawValid = 1;
    end
    checkOutput("midreset no result", 32'(sawValid), 32'd0);
    checkPixels("after midreset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    // Fresh pair after reset converts normally.
    convertPair("fresh", 1'b0);
    checkPixels("fresh", 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255);
    releaseOutput("fresh");

    // Inputs change during the multiply cycles; result follows the accepted pair.
    applyStimulus(8'd81, 8'd81, 8'd90, 8'd90, 8'd240, 8'd240);
    convertPair("scramble", 1'b1);
    checkPixels("scramble", 8'd254, 8'd0, 8'd0, 8'd254, 8'd0, 8'd0);
    releaseOutput("scramble");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
